seq_multiplier_32bit: RTL and testbench
=======================================

SEQ_MULTIPLIER_32BIT -- requirements
Module: seq_multiplier_32bit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
REQ-005 value1  input  32  multiplicand; captured on the accepting edge.
REQ-006 value2  input  32  multiplier; captured on the accepting edge.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 result  output  32  low product word; drives the ALU MULT input (select 3'b111).
REQ-010 result_hi  output  32  high product word, for the future HI register.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-012 IDLE + start SHALL latch both operands, clear the 64-bit accumulator and the 5-bit counter, and go to RUN; IDLE without start SHALL stay in IDLE.
REQ-013 RUN SHALL process one multiplier bit per cycle, LSB first: if bit=1, add the shifted multiplicand to the accumulator; then shift.
REQ-014 After the 32nd iteration (counter wraps 31->0) the FSM SHALL go to DONE; latency is 32 edges from the accepting edge to the edge that raises done.
REQ-015 On the RUN->DONE edge, result/result_hi SHALL load the product.
REQ-016 Outputs SHALL hold the product until the next RUN->DONE edge; they SHALL NOT change during a later RUN.
REQ-017 DONE SHALL last exactly one cycle; done=1 only in DONE.
REQ-018 DONE + start SHALL go directly to RUN (back-to-back); otherwise DONE SHALL go to IDLE.
REQ-019 start in RUN SHALL be ignored; no queuing; operands SHALL be unaffected.
REQ-020 Operand changes outside the accepting edge SHALL have no effect.
REQ-021 The product SHALL be the exact 64-bit result; there is no overflow or truncation flag.

Reset
REQ-022 When reset_n=0, state SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-023 During reset, busy, done, result, result_hi, the counter, the accumulator and the operand registers SHALL all be 0.
REQ-024 Reset during RUN SHALL discard the operation; no done pulse SHALL follow.
REQ-025 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-026 With MULT_SIGNED_EN defined, operands SHALL be two's complement: latch magnitudes and sign = value1[31]^value2[31], multiply magnitudes, and negate the 64-bit product on the RUN->DONE edge when sign=1. Latency is unchanged.
REQ-027 Without MULT_SIGNED_EN, operands and product SHALL be unsigned, and no sign logic SHALL be synthesized.

Structure
REQ-028 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10), WIDTH and ITER_COUNT=32 SHALL live in the shared MiniMIPS definitions package/header.
REQ-029 The per-iteration partial-sum add SHALL instantiate the existing adder_32bit (carry_in 0, carry_out into the accumulator's upper bit); no other sub-modules.

Verification
REQ-030 Unsigned 3 x 5: start at edge k -> done high after edge k+32, result=0x0000000F, result_hi=0, busy low after done.
REQ-031 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001, result_hi=0xFFFFFFFE.
REQ-032 MULT_SIGNED_EN, -7 x 6 -> result=0xFFFFFFD6, result_hi=0xFFFFFFFF; -1 x -1 -> result=1, result_hi=0.
REQ-033 start with 2 x 2 held high through all of RUN, operands changed to 9 x 9 mid-run -> exactly one done, result=4; the DONE-cycle start launches 9 x 9 -> result=81 thirty-two edges later.
REQ-034 reset_n pulsed low at RUN iteration 10 of 7 x 7 -> all outputs 0 asynchronously, no done; a fresh 7 x 7 then gives result=49.
REQ-035 Result hold: after 6 x 7 completes, a new 2 x 3 run SHALL keep result=42 throughout RUN, then change to 6 only on its done.

Source files
------------

// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: widths, iteration
// count and the FSM state encoding.
package seq_multiplier_32bit_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit ripple adder with carry in/out, used for the multiplier's
// per-iteration partial-sum add.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};

endmodule

// File: rtl/seq_multiplier_32bit.sv
// 32x32 -> 64-bit sequential shift-add multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude with final negate).
module seq_multiplier_32bit
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = seq_multiplier_32bit_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled on every rising edge but only accepted in
    // IDLE or DONE; done is a one-cycle pulse with result/result_hi valid.

    mult_state_e        state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   psum;
    logic               pcarry;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   mcand_load;
    logic [WIDTH-1:0]   mplier_load;

    assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_iter = (cnt_q == CNT_W'(ITER_COUNT - 1));
    assign addend    = mplier_q[0] ? mcand_q : '0;
    assign state_dbg = state_q;

    adder_32bit u_adder (
        .a         (acc_q[2*WIDTH-1:WIDTH]),
        .b         (addend),
        .carry_in  (1'b0),
        .sum       (psum),
        .carry_out (pcarry)
    );

    // Add into the upper half, then shift the whole accumulator right by one.
    assign acc_next = {pcarry, psum, acc_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic sign_q;

    assign mcand_load  = value1[WIDTH-1] ? (WIDTH'(0) - value1) : value1;
    assign mplier_load = value2[WIDTH-1] ? (WIDTH'(0) - value2) : value2;
    assign product     = sign_q ? ((2*WIDTH)'(0) - acc_next) : acc_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= value1[WIDTH-1] ^ value2[WIDTH-1];
        end
    end
`else
    assign mcand_load  = value1;
    assign mplier_load = value2;
    assign product     = acc_next;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
        end else if (accept) begin
            state_q  <= ST_RUN;
            mcand_q  <= mcand_load;
            mplier_q <= mplier_load;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                ST_RUN: begin
                    acc_q    <= acc_next;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q   <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= product[WIDTH-1:0];
                        result_hi <= product[2*WIDTH-1:WIDTH];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Directed self-checking bench for seq_multiplier_32bit; expected products are
// hand-computed constants (signed variants selected by MULT_SIGNED_EN).
module tb_seq_multiplier_32bit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] value1;
    logic [31:0] value2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic [1:0]  state_dbg;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Bench-side record of the last product the DUT should be holding.
    logic [31:0] last_lo;
    logic [31:0] last_hi;

    seq_multiplier_32bit dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .value1    (value1),
        .value2    (value2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic launch(input logic [31:0] v1, input logic [31:0] v2);
        value1 = v1;
        value2 = v2;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        value1 = $urandom;
        value2 = $urandom;
    endtask

    // Counts edges after the accepting edge until done; outputs must hold meanwhile.
    task automatic wait_done(input string tag, input logic [31:0] hold_lo,
                             input logic [31:0] hold_hi, output int lat);
        bit held;
        held = 1'b1;
        lat  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = i;
                break;
            end
            if (result !== hold_lo || result_hi !== hold_hi || busy !== 1'b1) held = 1'b0;
        end
        check({tag, "_hold"}, 64'(held), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd32);
    endtask

    task automatic run_op(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int lat;
        launch(v1, v2);
        wait_done(tag, last_lo, last_hi, lat);
        check({tag, "_lo"}, 64'(result), 64'(exp_lo));
        check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check({tag, "_state_done"}, 64'(state_dbg), 64'd2);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_state_idle"}, 64'(state_dbg), 64'd0);
        check({tag, "_keep"}, {result_hi, result}, {exp_hi, exp_lo});
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  held;
        bit  quiet;

        reset_n = 1'b0;
        start   = 1'b0;
        value1  = 32'd0;
        value2  = 32'd0;
        last_lo = 32'd0;
        last_hi = 32'd0;

        // Values held in reset.
        repeat (2) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", {result_hi, result}, 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);

        // Release and start together: first rising edge after reset accepts.
        reset_n = 1'b1;
        run_op("u3x5", 32'd3, 32'd5, 32'h0000_000F, 32'h0);

`ifdef MULT_SIGNED_EN
        run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32'hFFFF_FFFF);
        run_op("min_x2", 32'h8000_0000, 32'd2, 32'h0000_0000, 32'hFFFF_FFFF);
`else
        run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("msb_x2", 32'h8000_0000, 32'd2, 32'h0000_0000, 32'h0000_0001);
`endif
        run_op("zero", 32'd0, 32'h1234_5678, 32'h0, 32'h0);
        run_op("carry_hi", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
        run_op("ffff_x", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 32'h0000_0000);

        // start held high through RUN with operands changed mid-run.
        value1 = 32'd2;
        value2 = 32'd2;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("held_accept_busy", 64'(busy), 64'd1);
        held = 1'b1;
        lat  = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i == 10) begin
                value1 = 32'd9;
                value2 = 32'd9;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (result !== last_lo || result_hi !== last_hi) held = 1'b0;
        end
        check("held_hold", 64'(held), 64'd1);
        check("held_latency", 64'(lat), 64'd32);
        check("held_lo", 64'(result), 64'd4);
        check("held_hi", 64'(result_hi), 64'd0);
        // start still high in DONE: back-to-back launch of 9 x 9.
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_state_run", 64'(state_dbg), 64'd1);
        wait_done("b2b", 32'd4, 32'd0, lat);
        check("b2b_lo", 64'(result), 64'd81);
        check("b2b_hi", 64'(result_hi), 64'd0);
        last_lo = 32'd81;
        last_hi = 32'd0;
        @(posedge clock);
        @(negedge clock);

        // Reset at RUN iteration 10 discards the operation.
        launch(32'd7, 32'd7);
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", {result_hi, result}, 64'd0);
        check("arst_state", 64'(state_dbg), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_lo = 32'd0;
        last_hi = 32'd0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("arst_no_done", 64'(quiet), 64'd1);
        run_op("fresh7x7", 32'd7, 32'd7, 32'd49, 32'd0);

        // Result hold across a later run.
        run_op("hold6x7", 32'd6, 32'd7, 32'd42, 32'd0);
        run_op("hold2x3", 32'd2, 32'd3, 32'd6, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
